// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, programmable almost
// flags, overflow/underflow pulses and an optional first-word-fall-through read.
module sync_fifo_param #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned DEPTH      = 8,
   parameter int unsigned AF_THRESH  = DEPTH - 2,
   parameter int unsigned AE_THRESH  = 2,
   parameter bit          FWFT       = 1'b0
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    write,
   input  logic [DATA_WIDTH-1:0]   data_in,
   input  logic                    read,
   output logic [DATA_WIDTH-1:0]   data_out,
   output logic                    full,
   output logic                    empty,
   output logic                    almost_full,
   output logic                    almost_empty,
   output logic [$clog2(DEPTH):0]  count,
   output logic                    overflow,
   output logic                    underflow
);

   localparam int unsigned ADDR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W  = ADDR_W + 1;

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              ovf_q, ovf_d;
   logic              udf_q, udf_d;
   logic              wr_en, rd_en;
   logic [DATA_WIDTH-1:0] rd_word;

   // Handshake: a request is accepted on the edge where it is high and the
   // FIFO can take it (write while not full, read while not empty), judged on
   // the pre-edge count. A refused request leaves all state untouched and only
   // raises the matching error pulse for one cycle.
   always_comb begin
      wr_en    = write & ~full;
      rd_en    = read & ~empty;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      ovf_d    = write & full;
      udf_d    = read & empty;
      if (wr_en) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
      if (rd_en) rd_ptr_d = rd_ptr_q + ADDR_W'(1);
      case ({wr_en, rd_en})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
         udf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
         udf_q    <= udf_d;
      end
   end

   // Storage is deliberately not reset; the pointers alone define validity.
   always_ff @(posedge clk) begin
      if (wr_en && !reset) mem_q[wr_ptr_q] <= data_in;
   end

   assign rd_word = mem_q[rd_ptr_q];

   generate
      if (FWFT) begin : g_fwft
         assign data_out = empty ? '0 : rd_word;
      end else begin : g_std
         logic [DATA_WIDTH-1:0] dout_q, dout_d;

         always_comb begin
            dout_d = dout_q;
            if (rd_en) dout_d = rd_word;
         end

         always_ff @(posedge clk) begin
            if (reset) dout_q <= '0;
            else       dout_q <= dout_d;
         end

         assign data_out = dout_q;
      end
   endgenerate

   assign count        = count_q;
   assign full         = (count_q == CNT_W'(DEPTH));
   assign empty        = (count_q == '0);
   assign almost_full  = (count_q >= CNT_W'(AF_THRESH));
   assign almost_empty = (count_q <= CNT_W'(AE_THRESH));
   assign overflow     = ovf_q;
   assign underflow    = udf_q;

endmodule
